// File: rtl/alu_pkg.sv
// Shared ALU definitions: logic-unit function codes and result flag layout.
package alu_pkg;

    // Logic unit function select codes
    localparam logic [2:0] LOGIC_AND  = 3'b000;
    localparam logic [2:0] LOGIC_OR   = 3'b001;
    localparam logic [2:0] LOGIC_NAND = 3'b010;
    localparam logic [2:0] LOGIC_NOR  = 3'b011;
    localparam logic [2:0] LOGIC_XOR  = 3'b100;
    localparam logic [2:0] LOGIC_XNOR = 3'b101;
    localparam logic [2:0] LOGIC_NOT  = 3'b110;
    localparam logic [2:0] LOGIC_PASS = 3'b111;

    // Flag vector layout, shared with the arithmetic unit
    localparam int unsigned FLAG_W      = 2;
    localparam int unsigned FLAG_PARITY = 0;
    localparam int unsigned FLAG_ZERO   = 1;

endpackage

// File: rtl/logic_pipe_stage.sv
// One valid/ready register slice; accepts whenever empty or draining.
module logic_pipe_stage #(
    parameter int unsigned WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    // Load on accept, clear when drained with nothing behind, otherwise hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_ready) begin
            valid_q <= in_valid;
            if (in_valid) begin
                data_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined 8-function logic unit with zero/parity flags and valid/ready flow control.
module logic_unit_pipe
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned PIPE_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in1,
    input  logic [DATA_WIDTH-1:0] in2,
    input  logic [2:0]            logic_fun,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] logic_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_zero,
    output logic                  out_parity
);

    localparam int unsigned PW = DATA_WIDTH + FLAG_W;

    if (PIPE_STAGES < 1) begin : g_bad_stages
        $error("logic_unit_pipe: PIPE_STAGES must be at least 1");
    end

    logic [DATA_WIDTH-1:0] result;
    logic [FLAG_W-1:0]     flags;
    logic [PW-1:0]         payload_in;
    logic                  tail_valid;
    logic [PW-1:0]         tail_data;

    // Function decode and flag generation ahead of stage 0
    always_comb begin
        result = '0;
        case (logic_fun)
            LOGIC_AND:  result = in1 & in2;
            LOGIC_OR:   result = in1 | in2;
            LOGIC_NAND: result = ~(in1 & in2);
            LOGIC_NOR:  result = ~(in1 | in2);
            LOGIC_XOR:  result = in1 ^ in2;
            LOGIC_XNOR: result = ~(in1 ^ in2);
            LOGIC_NOT:  result = ~in1;
            LOGIC_PASS: result = in1;
            default:    result = '0;
        endcase
        flags              = '0;
        flags[FLAG_ZERO]   = (result == '0);
        flags[FLAG_PARITY] = ^result;
        payload_in         = {result, flags};
    end

    // Each generate block owns its upstream/downstream handshake signals so the
    // ready chain is a set of distinct nets rather than one self-referencing vector.
    for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
        logic          up_valid;
        logic          up_ready;
        logic [PW-1:0] up_data;
        logic          dn_valid;
        logic          dn_ready;
        logic [PW-1:0] dn_data;

        logic_pipe_stage #(.WIDTH(PW)) u_stage (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (up_valid),
            .in_ready  (up_ready),
            .in_data   (up_data),
            .out_valid (dn_valid),
            .out_ready (dn_ready),
            .out_data  (dn_data)
        );

        if (k == 0) begin : g_head
            assign up_valid = in_valid;
            assign up_data  = payload_in;
            assign in_ready = up_ready;
        end else begin : g_link
            assign up_valid = g_stage[k-1].dn_valid;
            assign up_data  = g_stage[k-1].dn_data;
        end

        if (k == PIPE_STAGES - 1) begin : g_tail
            assign dn_ready   = out_ready;
            assign tail_valid = dn_valid;
            assign tail_data  = dn_data;
        end else begin : g_mid
            assign dn_ready = g_stage[k+1].up_ready;
        end
    end

    // Present the last stage, forcing data and flags to zero while idle
    always_comb begin
        out_valid  = tail_valid;
        logic_out  = '0;
        out_zero   = 1'b0;
        out_parity = 1'b0;
        if (tail_valid) begin
            logic_out  = tail_data[PW-1:FLAG_W];
            out_zero   = tail_data[FLAG_ZERO];
            out_parity = tail_data[FLAG_PARITY];
        end
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed self-checking bench for logic_unit_pipe (DATA_WIDTH=16, PIPE_STAGES=2).
module tb_logic_unit_pipe;

    logic        clk;
    logic        rst;
    logic [15:0] in1;
    logic [15:0] in2;
    logic [2:0]  logic_fun;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] logic_out;
    logic        out_valid;
    logic        out_ready;
    logic        out_zero;
    logic        out_parity;

    int total = 0;
    int bad   = 0;
    int stalls = 0;
    logic [17:0] exp_q [$];
    logic [17:0] prev;
    logic        prev_stall = 1'b0;

    logic_unit_pipe #(.DATA_WIDTH(16), .PIPE_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .in1        (in1),
        .in2        (in2),
        .logic_fun  (logic_fun),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .logic_out  (logic_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_zero   (out_zero),
        .out_parity (out_parity)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Offer one operation and hold it until accepted; expected packing {zero, parity, data}
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [2:0] f,
                        input logic [15:0] d, input logic z, input logic p);
        int n;
        in1 = a; in2 = b; logic_fun = f; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            stalls++;
            n++;
            @(negedge clk);
        end
        if (!in_ready) check("send_timeout", 32'd0, 32'd1);
        else exp_q.push_back({z, p, d});
        @(posedge clk); #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; in1 = '0; in2 = '0; logic_fun = '0;
    endtask

    task automatic drain();
        int n;
        idle();
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    // Output monitor: in-order results, hold-while-stalled, zero-when-idle, no extras
    always @(negedge clk) begin
        logic [17:0] cur;
        logic [17:0] e;
        cur = {out_zero, out_parity, logic_out};
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (!out_valid) begin
                check("idle_zero", {14'd0, cur}, 32'd0);
            end else begin
                if (prev_stall) check("hold", {14'd0, cur}, {14'd0, prev});
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("spurious", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("result", {14'd0, cur}, {14'd0, e});
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev       = cur;
        end
    end

    initial begin
        rst = 1'b1; out_ready = 1'b1;
        idle();
        #3;
        check("rst_valid", out_valid, 0);
        check("rst_data", {out_zero, out_parity, logic_out}, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // AND with latency check
        send(16'hF0F0, 16'hFF00, 3'b000, 16'hF000, 1'b0, 1'b0);
        check("lat_early", out_valid, 0);
        idle();
        @(posedge clk); #1;
        check("lat_due", out_valid, 1);
        drain();

        // All functions back-to-back, then XOR of equal operands
        stalls = 0;
        send(16'h1234, 16'h00FF, 3'b000, 16'h0034, 1'b0, 1'b1);
        send(16'h1234, 16'h00FF, 3'b001, 16'h12FF, 1'b0, 1'b0);
        send(16'h1234, 16'h00FF, 3'b010, 16'hFFCB, 1'b0, 1'b1);
        send(16'h1234, 16'h00FF, 3'b011, 16'hED00, 1'b0, 1'b0);
        send(16'h1234, 16'h00FF, 3'b100, 16'h12CB, 1'b0, 1'b1);
        send(16'h1234, 16'h00FF, 3'b101, 16'hED34, 1'b0, 1'b1);
        send(16'h1234, 16'h00FF, 3'b110, 16'hEDCB, 1'b0, 1'b1);
        send(16'h1234, 16'h00FF, 3'b111, 16'h1234, 1'b0, 1'b1);
        send(16'h1234, 16'h1234, 3'b100, 16'h0000, 1'b1, 1'b0);
        check("sweep_no_stall", stalls, 0);
        drain();

        // Parity
        send(16'h0001, 16'h0001, 3'b010, 16'hFFFE, 1'b0, 1'b1);
        send(16'h0000, 16'h0000, 3'b011, 16'hFFFF, 1'b0, 1'b0);
        drain();

        // Backpressure: out_ready low for cycles 3..6 of a 6-op stream
        stalls = 0;
        fork
            begin
                send(16'h0001, 16'h0000, 3'b111, 16'h0001, 1'b0, 1'b1);
                send(16'h0002, 16'h0000, 3'b111, 16'h0002, 1'b0, 1'b1);
                send(16'h0003, 16'h0000, 3'b111, 16'h0003, 1'b0, 1'b0);
                send(16'h0004, 16'h0000, 3'b111, 16'h0004, 1'b0, 1'b1);
                send(16'h0005, 16'h0000, 3'b111, 16'h0005, 1'b0, 1'b0);
                send(16'h0006, 16'h0000, 3'b111, 16'h0006, 1'b0, 1'b0);
                idle();
            end
            begin
                out_ready = 1'b1;
                repeat (3) begin @(posedge clk); #1; end
                out_ready = 1'b0;
                @(negedge clk);
                @(negedge clk);
                check("bp_full", in_ready, 0);
                @(posedge clk); @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        check("bp_stalled", stalls > 0, 1);
        drain();

        // Bubble collapse: only the last stage full, downstream stalled
        out_ready = 1'b0;
        send(16'h00A5, 16'h0000, 3'b111, 16'h00A5, 1'b0, 1'b0);
        idle();
        @(posedge clk); #1;
        @(negedge clk);
        check("bub_ready", in_ready, 1);
        check("bub_valid", out_valid, 1);
        @(posedge clk); #1;
        send(16'h8000, 16'h0000, 3'b111, 16'h8000, 1'b0, 1'b1);
        idle();
        @(negedge clk);
        check("bub_full", in_ready, 0);
        @(posedge clk); #1;
        drain();

        // Reset with two operations in flight
        out_ready = 1'b0;
        send(16'h0F0F, 16'h0000, 3'b111, 16'h0F0F, 1'b0, 1'b0);
        send(16'h00F0, 16'h0000, 3'b111, 16'h00F0, 1'b0, 1'b0);
        idle();
        @(negedge clk);
        check("pre_rst_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", logic_out, 0);
        exp_q.delete();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", in_ready, 1);
        out_ready = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        check("no_stale", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/logic_unit_pipe.md
# logic_unit_pipe

Parametrised, pipelined successor to the single-cycle logic unit. It adds three things: a wider function set (8 bitwise operations), a valid/ready handshake on both sides with full backpressure, and a configurable number of pipeline stages. Each result carries zero and parity flags. The block sits in the ALU datapath beside the arithmetic and shift units and is driven by the ALU decoder.

## Interface
- `DATA_WIDTH`, default 16: operand and result width.
- `PIPE_STAGES`, default 2: number of register stages (≥1); latency in cycles.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in1`  in  DATA_WIDTH: operand A.
- `in2`  in  DATA_WIDTH: operand B.
- `logic_fun`  in  3: function select, sampled with the operands.
- `in_valid`  in  1: operands and function are valid this cycle.
- `in_ready`  out  1: block accepts the operation this cycle.
- `logic_out`  out  DATA_WIDTH: result.
- `out_valid`  out  1: the result is valid (replaces the old logic_flag).
- `out_ready`  in  1: the downstream side accepts the result.
- `out_zero`  out  1: result is all zeros.
- `out_parity`  out  1: XOR-reduce of the result (1 = odd number of ones).

## Operation
- Function codes:
  - 000 AND
  - 001 OR
  - 010 NAND
  - 011 NOR
  - 100 XOR
  - 101 XNOR
  - 110 NOT in1
  - 111 PASS in1
- An input transfer occurs when `in_valid && in_ready`.
- On transfer, the result and both flags are computed combinationally and captured into stage 0.
- Stages 1..PIPE_STAGES-1 only carry `{valid, data, zero, parity}`.
- Per-stage ready: `stage_ready[k] = !valid[k] || stage_ready[k+1]`; the last stage uses `out_ready`. `in_ready = stage_ready[0]`.
- Bubbles collapse: an empty stage accepts data even while downstream stalls.
- An output transfer occurs when `out_valid && out_ready`. A stage holds its contents unchanged while stalled.
- `logic_out`, `out_zero` and `out_parity` are forced to 0 whenever `out_valid=0`, matching the zero-when-idle behaviour of the previous unit.
- Operations complete in strict issue order. Nothing is dropped or duplicated.
- Capacity is PIPE_STAGES operations in flight.

## Timing
- Reset (async assert, synchronous release to first `clk` edge) sets:
  - all stage valid bits and data/flag registers to 0;
  - outputs to `out_valid=0`, `logic_out=0`, `out_zero=0`, `out_parity=0`;
  - `in_ready=1` from the first cycle after release.
- Latency: an operation accepted at edge N is presented at the output after edge N+PIPE_STAGES-1. It is visible for the whole cycle following that edge, i.e. PIPE_STAGES cycles from `in_valid` to `out_valid`.
- Throughput: 1 operation per cycle while `out_ready=1`.
- Full pipeline with `out_ready=0`: `in_ready=0` in the same cycle (combinational chain). Inputs must be held by the sender per the valid/ready rules.
- Full pipeline with `out_ready=1`: simultaneous output and input transfer in the same cycle, with no bubble.
- `in_ready` depends combinationally on `out_ready`. `out_valid` and the data outputs do not depend combinationally on any input.
- Reset mid-stream discards all in-flight operations immediately. No result emerges afterwards.

## Structure
- Shared package `alu_pkg`:
  - function-code localparams (`LOGIC_AND` … `LOGIC_PASS`);
  - flag bit ordering, shared with the arithmetic unit.
- Sub-module `logic_pipe_stage`: one register slice with valid/ready, parametrised on payload width (DATA_WIDTH+2).
- The top level instantiates a generate chain of PIPE_STAGES slices behind the combinational function/flag logic.
- Elaboration-time check: PIPE_STAGES ≥ 1.

## Test plan
All scenarios use DATA_WIDTH=16, PIPE_STAGES=2.
- **AND:** in1=0xF0F0, in2=0xFF00, fun=000, single op, `out_ready=1` → `out_valid` 2 cycles later, `logic_out`=0xF000, zero=0, parity=0.
- **All functions, back-to-back:** sweep all 8 codes on in1=0x1234, in2=0x00FF. Expect results 0x0034, 0x12FF, 0xFFCB, 0xED00, 0x12CB, 0xED34, 0xEDCB, 0x1234 on 8 consecutive cycles. Check the XOR of equal operands (0x1234^0x1234) gives 0x0000 with zero=1.
- **Parity:** NAND 0x0001,0x0001 → 0xFFFE, parity=1. NOR 0x0000,0x0000 → 0xFFFF, parity=0.
- **Backpressure:** stream 6 ops with `out_ready=0` for cycles 3–6.
  - `in_ready` falls once 2 ops are held.
  - Outputs hold stable while stalled.
  - All 6 results emerge in order, with none lost or duplicated.
- **Bubble collapse:** fill stage 1 only, hold `out_ready=0` → `in_ready` stays 1 for one more accept, then falls.
- **Reset mid-stream:** assert `rst` with 2 ops in flight →
  - immediately `out_valid=0`, `logic_out=0`;
  - after release, `in_ready=1` and no stale result appears.
